// File: rtl/event_unit_pkg.sv
// Shared register map for the event unit front-end and service unit.
// Index constants decode PADDR[4:2].
package event_unit_pkg;
  localparam int REG_IDX_W = 3;
  localparam int REGS_MAX_IDX = 4;

  localparam logic [REG_IDX_W-1:0] REG_RISE_EN    = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_FALL_EN    = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_LEVEL      = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_SW_TRIG    = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_FILTER_LEN = 3'd4;
endpackage

// File: rtl/event_line_cond.sv
// One event line: 2-flop sync, optional glitch filter, edge detect.
// Filter built only when EVENT_FILTER_EN is defined.
module event_line_cond
`ifdef EVENT_FILTER_EN
#(
  parameter int FILT_CNT_WIDTH = 4
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_event,
`ifdef EVENT_FILTER_EN
  input  logic [FILT_CNT_WIDTH-1:0] i_filt_len,
  input  logic                      i_filt_clr,
`endif
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_lvl_d;
  logic w_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl_d <= 1'b0;
    end else begin
      r_s1    <= i_event;
      r_s2    <= r_s1;
      r_lvl_d <= w_lvl;
    end
  end

`ifdef EVENT_FILTER_EN
  logic                      r_lvl;
  logic [FILT_CNT_WIDTH-1:0] r_cnt;
  logic [FILT_CNT_WIDTH:0]   w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

  // Length 0 behaves like 1: the compare is >=, so cnt never passes len.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else if (i_filt_clr) begin
      r_cnt <= '0;
    end else if (r_s2 == r_lvl) begin
      r_cnt <= '0;
    end else if (w_cnt_inc >= {1'b0, i_filt_len}) begin
      r_lvl <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc[FILT_CNT_WIDTH-1:0];
    end
  end

  assign w_lvl = r_lvl;
`else
  assign w_lvl = r_s2;
`endif

  assign o_lvl  = w_lvl;
  assign o_rise = w_lvl & ~r_lvl_d;
  assign o_fall = ~w_lvl & r_lvl_d;

endmodule

// File: rtl/event_edge_detector.sv
// Event front-end: sync, edge detect, SW trigger, APB regs, pulse reg.
// Optional per-line glitch filter enabled by EVENT_FILTER_EN.
module event_edge_detector
  import event_unit_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_LINES      = 32,
  parameter int FILT_CNT_WIDTH = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_LINES-1:0]      event_i,
  output logic [NUM_LINES-1:0]      signal_o
);

  logic [REG_IDX_W-1:0] w_idx;
  logic                 w_acc;
  logic                 w_wr;
  logic                 w_rd;
  logic [NUM_LINES-1:0] w_wdata;
  logic [NUM_LINES-1:0] w_sw_trig;
  logic [NUM_LINES-1:0] w_lvl;
  logic [NUM_LINES-1:0] w_rise;
  logic [NUM_LINES-1:0] w_fall;
  logic [NUM_LINES-1:0] r_rise_en;
  logic [NUM_LINES-1:0] r_fall_en;
  logic [NUM_LINES-1:0] r_sig;
  logic                 w_unused;

  assign w_idx   = PADDR[4:2];
  assign w_acc   = PSEL && PENABLE;
  assign w_wr    = w_acc && PWRITE;
  assign w_rd    = w_acc && !PWRITE;
  assign w_wdata = PWDATA[NUM_LINES-1:0];
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign w_unused = ^{PADDR, PWDATA};

  assign w_sw_trig = (w_wr && (w_idx == REG_SW_TRIG)) ? w_wdata : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_wr) begin
      if (w_idx == REG_RISE_EN) r_rise_en <= w_wdata;
      if (w_idx == REG_FALL_EN) r_fall_en <= w_wdata;
    end
  end

`ifdef EVENT_FILTER_EN
  logic [FILT_CNT_WIDTH-1:0] r_filt_len;
  logic                      w_filt_clr;

  assign w_filt_clr = w_wr && (w_idx == REG_FILTER_LEN);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_filt_len <= '0;
    end else if (w_filt_clr) begin
      r_filt_len <= PWDATA[FILT_CNT_WIDTH-1:0];
    end
  end
`else
  localparam int lp_unused_filt_w = FILT_CNT_WIDTH;
`endif

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
`ifdef EVENT_FILTER_EN
    event_line_cond #(
      .FILT_CNT_WIDTH (FILT_CNT_WIDTH)
    ) u_line (
      .clk        (HCLK),
      .rst_n      (HRESETn),
      .i_event    (event_i[g]),
      .i_filt_len (r_filt_len),
      .i_filt_clr (w_filt_clr),
      .o_lvl      (w_lvl[g]),
      .o_rise     (w_rise[g]),
      .o_fall     (w_fall[g])
    );
`else
    event_line_cond u_line (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .i_event (event_i[g]),
      .o_lvl   (w_lvl[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
`endif
  end

  // HW edge and SW trigger are ORed so a coincidence yields one pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sig <= '0;
    end else begin
      r_sig <= (w_rise & r_rise_en)
             | (w_fall & r_fall_en)
             | w_sw_trig;
    end
  end

  assign signal_o = r_sig;

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      unique case (1'b1)
        (w_idx == REG_RISE_EN): PRDATA = 32'(r_rise_en);
        (w_idx == REG_FALL_EN): PRDATA = 32'(r_fall_en);
        (w_idx == REG_LEVEL):   PRDATA = 32'(w_lvl);
`ifdef EVENT_FILTER_EN
        (w_idx == REG_FILTER_LEN): PRDATA = 32'(r_filt_len);
`endif
        default:                PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_event_edge_detector.sv
// Self-checking bench for event_edge_detector (default build).
// Reference: pulses derived from the delayed history of event_i.
module tb_event_edge_detector;

  localparam int AW = 12;
  localparam int NL = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic          PREADY;
  logic          PSLVERR;
  logic [NL-1:0] event_i;
  logic [NL-1:0] signal_o;

  int checks = 0;
  int errors = 0;

  // h1/h2/h3: event_i seen before the last 1/2/3 edges
  logic [31:0] h1, h2, h3;
  logic [31:0] m_rise, m_fall;
  logic [31:0] exp_sig;

  always #5 HCLK = ~HCLK;

  event_edge_detector dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .event_i  (event_i),
    .signal_o (signal_o)
  );

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0;
    m_rise = '0; m_fall = '0;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    logic [31:0] sw;
    logic        wr;
    wr = PSEL && PENABLE && PWRITE;
    sw = (wr && PADDR[4:2] == 3'd3) ? PWDATA : 32'h0;
    exp_sig = (h2 & ~h3 & m_rise) | (~h2 & h3 & m_fall) | sw;
    if (wr && PADDR[4:2] == 3'd0) m_rise = PWDATA;
    if (wr && PADDR[4:2] == 3'd1) m_fall = PWDATA;
    h3 = h2; h2 = h1; h1 = event_i;
    @(posedge HCLK);
    #1;
    checks++;
    if (signal_o !== exp_sig) begin
      errors++;
      $display("FAIL model_sig t=%0t got %h exp %h", $time, signal_o, exp_sig);
    end
    @(negedge HCLK);
  endtask

  task automatic apb_write(input logic [2:0] idx, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = {7'b0, idx, 2'b00}; PWDATA = d;
    cycle();
    PENABLE = 1'b1;
    cycle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [31:0] d,
                          output logic [31:0] lvl);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = {7'b0, idx, 2'b00};
    cycle();
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    lvl = h2;
    cycle();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    logic [31:0] d, lvl;
    for (int i = 0; i < 8; i++) begin
      apb_read(3'(i), d, lvl);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL %s_reg%0d got %h exp 0", tag, i, d);
      end
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0;
    PADDR = '0; PWDATA = '0; event_i = '0;
    model_reset();
    repeat (2) @(negedge HCLK);
    checks++;
    if (signal_o !== '0 || PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got sig=%h rdy=%b err=%b exp 0/1/0",
               signal_o, PREADY, PSLVERR);
    end
    HRESETn = 1'b1;
    read_all_zero("reset");
  endtask

  task automatic test_rise();
    apb_write(3'd0, 32'h1);
    event_i[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (signal_o !== ((i == 2) ? 32'h1 : 32'h0)) begin
        errors++;
        $display("FAIL rise_cyc%0d got %h exp %h", i, signal_o,
                 (i == 2) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic test_fall();
    int cnt;
    apb_write(3'd0, 32'h0);
    apb_write(3'd1, 32'h8000_0000);
    event_i[31] = 1'b1;
    cnt = 0;
    repeat (5) begin cycle(); cnt += int'(signal_o[31]); end
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL fall_rise_ignored got %0d exp 0", cnt);
    end
    event_i[31] = 1'b0;
    cnt = 0;
    repeat (5) begin cycle(); cnt += int'(signal_o[31]); end
    checks++;
    if (cnt != 1) begin
      errors++; $display("FAIL fall_pulse got %0d exp 1", cnt);
    end
    event_i[31] = 1'b1;
    cnt = 0;
    repeat (5) begin cycle(); cnt += int'(signal_o[31]); end
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL fall_rerise got %0d exp 0", cnt);
    end
  endtask

  task automatic test_sw_coincide();
    apb_write(3'd1, 32'h0);
    apb_write(3'd0, 32'h1);
    event_i[0] = 1'b0;
    repeat (4) cycle();
    event_i[0] = 1'b1;
    cycle();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = {7'b0, 3'd3, 2'b00}; PWDATA = 32'h5;
    cycle();
    PENABLE = 1'b1;
    cycle();
    checks++;
    if (signal_o !== 32'h5) begin
      errors++; $display("FAIL sw_coincide got %h exp 00000005", signal_o);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    cycle();
    checks++;
    if (signal_o !== 32'h0) begin
      errors++; $display("FAIL sw_selfclear got %h exp 0", signal_o);
    end
  endtask

  task automatic test_enable_change();
    int cnt;
    logic [31:0] d, lvl;
    apb_write(3'd0, 32'h0);
    event_i[3] = 1'b1;
    cnt = 0;
    repeat (4) begin cycle(); cnt += int'(signal_o[3]); end
    apb_write(3'd0, 32'h8);
    repeat (4) begin cycle(); cnt += int'(signal_o[3]); end
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL late_enable got %0d pulses exp 0", cnt);
    end
    apb_read(3'd2, d, lvl);
    checks++;
    if (d[3] !== 1'b1 || d !== lvl) begin
      errors++; $display("FAIL level_read got %h exp %h", d, lvl);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    apb_write(3'd0, 32'h20);
    apb_write(3'd1, 32'h20);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) event_i[5] = ~event_i[5];
      cycle();
      cnt += int'(signal_o[5]);
    end
    repeat (4) begin cycle(); cnt += int'(signal_o[5]); end
    checks++;
    if (cnt != 8) begin
      errors++; $display("FAIL back_to_back got %0d pulses exp 8", cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      event_i = event_i ^ ($urandom() & $urandom());
      if (!PSEL) begin
        if ($urandom_range(0, 5) == 0) begin
          PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
          case ($urandom_range(0, 2))
            0:       PADDR = {7'b0, 3'd0, 2'b00};
            1:       PADDR = {7'b0, 3'd1, 2'b00};
            default: PADDR = {7'b0, 3'd3, 2'b00};
          endcase
          PWDATA = $urandom() & $urandom();
        end
      end else if (!PENABLE) begin
        PENABLE = 1'b1;
      end else begin
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      end
      cycle();
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    event_i = '0;
    apb_write(3'd0, 32'h0);
    apb_write(3'd1, 32'h0);
    repeat (4) cycle();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = {7'b0, 3'd3, 2'b00}; PWDATA = 32'hFFFF_0000;
    cycle();
    PENABLE = 1'b1;
    @(posedge HCLK);
    #1;
    checks++;
    if (signal_o !== 32'hFFFF_0000) begin
      errors++; $display("FAIL pre_reset_pulse got %h exp ffff0000", signal_o);
    end
    HRESETn = 1'b0;
    #1;
    checks++;
    if (signal_o !== 32'h0) begin
      errors++; $display("FAIL async_reset got %h exp 0", signal_o);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    model_reset();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    read_all_zero("post_reset");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_sw_coincide();
    test_enable_change();
    test_back_to_back();
    test_random();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
